// File: rtl/dma_sequencer.sv
// dma_sequencer: moves a block of words between the ping-pong buffer and a burst bus, split into bursts.
// Latency: a launch pulse is accepted in IDLE and acted on from the next cycle; bus phases follow grant/beat handshakes.
// Backpressure: waits for bus_grant, and for data_valid (read) or bus_busy low (write) on every beat. Optional DMA_SEQ_ERROR_EN: bus_error aborts.
module dma_sequencer (
  input  logic        system_clk,
  input  logic        n_reset,
  input  logic        launch_write,
  input  logic        launch_read,
  input  logic        launch_simple_switch,
  input  logic [31:0] start_address,
  input  logic [3:0]  byte_enable,
  input  logic [7:0]  burst_size,
  input  logic [7:0]  block_size_in,
  output logic        busy,
  output logic        operation_done,
  output logic [7:0]  block_size_out,
  output logic        bus_request,
  input  logic        bus_grant,
  output logic        begin_transaction,
  output logic        end_transaction,
  output logic [31:0] address_data_out,
  output logic [3:0]  byte_enables_out,
  output logic [7:0]  burst_size_out,
  output logic        read_n_write,
  input  logic        data_valid,
  input  logic        bus_busy,
  input  logic [31:0] address_data_in,
  input  logic        bus_error,
  output logic [8:0]  pp_address,
  output logic        pp_writeEnable,
  output logic [31:0] pp_dataIn,
  input  logic [31:0] pp_dataOut,
  output logic        pp_switch,
  output logic        error_flag
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SWITCH  = 3'd1;
  localparam logic [2:0] ST_REQUEST = 3'd2;
  localparam logic [2:0] ST_INIT    = 3'd3;
  localparam logic [2:0] ST_DATA    = 3'd4;
  localparam logic [2:0] ST_END     = 3'd5;
  localparam logic [2:0] ST_DONE    = 3'd6;

  localparam logic [1:0] OP_WRITE  = 2'd0;
  localparam logic [1:0] OP_READ   = 2'd1;
  localparam logic [1:0] OP_SWITCH = 2'd2;

  logic [2:0]  state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [7:0]  burst_q, burst_d;
  logic [7:0]  remaining_q, remaining_d;
  logic [7:0]  index_q, index_d;
  logic [7:0]  beat_q, beat_d;
  logic [7:0]  blen_q, blen_d;
  logic [7:0]  bso_q, bso_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;

  logic        is_read;
  logic        accept;
  logic        bus_abort;
  logic        aborted;
  logic        beat_take;
  logic [7:0]  burst_len_calc;
  logic [8:0]  beats_done;
  logic [7:0]  remaining_after;

  assign is_read = (op_q == OP_READ);
  assign accept  = (state_q == ST_IDLE) & (launch_write | launch_read | launch_simple_switch);

  // min(burst+1, remaining) - 1 rewritten as min(burst, remaining-1) to stay 8 bits wide
  assign burst_len_calc  = (burst_q < remaining_q) ? burst_q : (remaining_q - 8'd1);
  assign beats_done      = {1'b0, blen_q} + 9'd1;
  assign remaining_after = remaining_q - beats_done[7:0];

`ifdef DMA_SEQ_ERROR_EN
  logic err_q, err_d;

  assign bus_abort = bus_error & (state_q == ST_DATA);
  assign aborted   = err_q;

  // Error flag: cleared by an accepted launch, set when the bus reports an error mid-burst
  always_comb begin
    err_d = err_q;
    if (accept) begin
      err_d = 1'b0;
    end else if (bus_abort) begin
      err_d = 1'b1;
    end
  end

  // Error flag register
  always_ff @(posedge system_clk or negedge n_reset) begin
    if (!n_reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign error_flag = err_q;
`else
  logic unused_bus_error;

  assign unused_bus_error = bus_error;
  assign bus_abort        = 1'b0;
  assign aborted          = 1'b0;
  assign error_flag       = 1'b0;
`endif

  // A beat completes on data_valid for reads and on a non-busy bus cycle for writes
  assign beat_take = (state_q == ST_DATA) & ~bus_abort & (is_read ? data_valid : ~bus_busy);

  // Sequencer next-state and datapath updates
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    be_d        = be_q;
    burst_d     = burst_q;
    remaining_d = remaining_q;
    index_d     = index_q;
    beat_d      = beat_q;
    blen_d      = blen_q;
    bso_d       = bso_q;
    done_d      = done_q;
    busy_d      = accept | (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          addr_d      = start_address;
          be_d        = byte_enable;
          burst_d     = burst_size;
          remaining_d = block_size_in;
          index_d     = 8'd0;
          done_d      = 1'b0;
          if (launch_write) begin
            op_d    = OP_WRITE;
            state_d = ST_SWITCH;
          end else if (launch_read) begin
            op_d = OP_READ;
            if (block_size_in == 8'd0) begin
              bso_d   = 8'd0;
              state_d = ST_SWITCH;
            end else begin
              state_d = ST_REQUEST;
            end
          end else begin
            op_d    = OP_SWITCH;
            state_d = ST_SWITCH;
          end
        end
      end
      ST_SWITCH: begin
        // Only a write with words to send continues to the bus after the buffer swap
        state_d = ((op_q == OP_WRITE) && (remaining_q != 8'd0)) ? ST_REQUEST : ST_DONE;
      end
      ST_REQUEST: begin
        if (bus_grant) begin
          state_d = ST_INIT;
        end
      end
      ST_INIT: begin
        blen_d  = burst_len_calc;
        beat_d  = 8'd0;
        state_d = ST_DATA;
      end
      ST_DATA: begin
        if (bus_abort) begin
          state_d = ST_END;
        end else if (beat_take) begin
          index_d = index_q + 8'd1;
          beat_d  = beat_q + 8'd1;
          if (beat_q == blen_q) begin
            state_d = ST_END;
          end
        end
      end
      ST_END: begin
        addr_d      = addr_q + {21'd0, beats_done, 2'b00};
        remaining_d = remaining_after;
        if (aborted) begin
          if (is_read) begin
            bso_d = index_q;
          end
          state_d = ST_DONE;
        end else if (remaining_after != 8'd0) begin
          state_d = ST_REQUEST;
        end else if (is_read) begin
          bso_d   = index_q;
          state_d = ST_SWITCH;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any transfer in flight
  always_ff @(posedge system_clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_WRITE;
      addr_q      <= 32'd0;
      be_q        <= 4'hF;
      burst_q     <= 8'd0;
      remaining_q <= 8'd0;
      index_q     <= 8'd0;
      beat_q      <= 8'd0;
      blen_q      <= 8'd0;
      bso_q       <= 8'd0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      burst_q     <= burst_d;
      remaining_q <= remaining_d;
      index_q     <= index_d;
      beat_q      <= beat_d;
      blen_q      <= blen_d;
      bso_q       <= bso_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign busy              = busy_q;
  assign operation_done    = done_q;
  assign block_size_out    = bso_q;
  assign bus_request       = (state_q == ST_REQUEST) | (state_q == ST_INIT) |
                             (state_q == ST_DATA) | (state_q == ST_END);
  assign begin_transaction = (state_q == ST_INIT);
  assign end_transaction   = (state_q == ST_END);
  assign pp_switch         = (state_q == ST_SWITCH);
  assign byte_enables_out  = (state_q == ST_INIT) ? be_q : 4'hF;
  assign burst_size_out    = (state_q == ST_INIT) ? burst_len_calc : 8'd0;
  assign read_n_write      = is_read & ((state_q == ST_INIT) | (state_q == ST_DATA) | (state_q == ST_END));
  assign pp_writeEnable    = is_read & beat_take;
  assign pp_dataIn         = pp_writeEnable ? address_data_in : 32'd0;

  // Bus address/data: address in INIT, buffer read data during write beats
  always_comb begin
    address_data_out = 32'd0;
    if (state_q == ST_INIT) begin
      address_data_out = addr_q;
    end else if ((state_q == ST_DATA) && !is_read) begin
      address_data_out = pp_dataOut;
    end
  end

  // Buffer address: writes pre-fetch the next word (index_d) through the one-cycle read port
  always_comb begin
    pp_address = 9'd0;
    if (is_read && (state_q == ST_DATA)) begin
      pp_address = {1'b0, index_q};
    end else if (!is_read && ((state_q == ST_INIT) || (state_q == ST_DATA))) begin
      pp_address = {1'b0, index_d};
    end
  end

endmodule

// File: tb/tb_dma_sequencer.sv
`timescale 1ns/1ps
module tb_dma_sequencer;

  logic        system_clk = 1'b0;
  logic        n_reset;
  logic        launch_write, launch_read, launch_simple_switch;
  logic [31:0] start_address;
  logic [3:0]  byte_enable;
  logic [7:0]  burst_size, block_size_in;
  logic        busy, operation_done;
  logic [7:0]  block_size_out;
  logic        bus_request, bus_grant, begin_transaction, end_transaction;
  logic [31:0] address_data_out;
  logic [3:0]  byte_enables_out;
  logic [7:0]  burst_size_out;
  logic        read_n_write, data_valid, bus_busy, bus_error;
  logic [31:0] address_data_in;
  logic [8:0]  pp_address;
  logic        pp_writeEnable, pp_switch, error_flag;
  logic [31:0] pp_dataIn, pp_dataOut;

  dma_sequencer dut (
    .system_clk(system_clk), .n_reset(n_reset),
    .launch_write(launch_write), .launch_read(launch_read), .launch_simple_switch(launch_simple_switch),
    .start_address(start_address), .byte_enable(byte_enable), .burst_size(burst_size),
    .block_size_in(block_size_in), .busy(busy), .operation_done(operation_done),
    .block_size_out(block_size_out), .bus_request(bus_request), .bus_grant(bus_grant),
    .begin_transaction(begin_transaction), .end_transaction(end_transaction),
    .address_data_out(address_data_out), .byte_enables_out(byte_enables_out),
    .burst_size_out(burst_size_out), .read_n_write(read_n_write), .data_valid(data_valid),
    .bus_busy(bus_busy), .address_data_in(address_data_in), .bus_error(bus_error),
    .pp_address(pp_address), .pp_writeEnable(pp_writeEnable), .pp_dataIn(pp_dataIn),
    .pp_dataOut(pp_dataOut), .pp_switch(pp_switch), .error_flag(error_flag)
  );

  always #5 system_clk = ~system_clk;

  int n_chk = 0;
  int n_fail = 0;

  // Ping-pong buffer model: read data is a seeded function of the address, bus reads land in pp_mem
  logic [31:0] pp_mem [512];
  logic [31:0] pp_rd_q;
  logic [31:0] wr_seed = 32'h1234_5678;
  always @(posedge system_clk) begin
    if (pp_writeEnable) pp_mem[pp_address] <= pp_dataIn;
    pp_rd_q <= wr_seed ^ ({23'd0, pp_address} * 32'h9E37_79B1);
  end
  assign pp_dataOut = pp_rd_q;

  function automatic logic [31:0] wr_word(input int i);
    return wr_seed ^ (i[31:0] * 32'h9E37_79B1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  logic [31:0] got_addr[$];
  logic [7:0]  got_len[$];
  logic [31:0] wr_got[$];
  logic [31:0] rd_exp[$];
  int          sw_cnt, end_cnt, be_bad, rnw_bad, end_miss;
  logic [7:0]  exp_bso = 8'd0;
  bit          noise_err = 1'b0;

  // One complete operation with a bus/buffer responder, then checked against the burst-splitting rule
  task automatic run_op(input int op, input logic [31:0] addr, input logic [3:0] be,
                        input logic [7:0] burst, input logic [7:0] block, input bit alt, input bit dual);
    bit in_data = 0, expect_end = 0, tick = 0, go, done_seen = 0, busy_seen = 0;
    int left = 0, rem, b, k;
    logic [31:0] a;
    got_addr.delete(); got_len.delete(); wr_got.delete(); rd_exp.delete();
    sw_cnt = 0; end_cnt = 0; be_bad = 0; rnw_bad = 0; end_miss = 0;
    wr_seed = $urandom;
    start_address = addr; byte_enable = be; burst_size = burst; block_size_in = block;
    launch_write = (op == 0);
    launch_read = (op == 1) || dual;
    launch_simple_switch = (op == 2);
    @(negedge system_clk);
    launch_write = 0; launch_read = 0; launch_simple_switch = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (operation_done) begin done_seen = 1; break; end
      if (busy) busy_seen = 1;
      launch_read = dual && (cyc == 3);
      if (expect_end && !end_transaction) end_miss++;
      expect_end = 0;
      if (end_transaction) end_cnt++;
      if (pp_switch) sw_cnt++;
      bus_busy = 0; data_valid = 0; bus_error = 0;
      bus_grant = bus_request && (alt || ($urandom_range(0, 2) == 0));
      if (begin_transaction) begin
        got_addr.push_back(address_data_out);
        got_len.push_back(burst_size_out);
        if (byte_enables_out !== be) be_bad++;
        if (read_n_write !== (op == 1)) rnw_bad++;
        left = int'(burst_size_out) + 1;
        in_data = 1;
      end else if (in_data) begin
        go = alt ? tick : ($urandom_range(0, 2) != 0);
        tick = ~tick;
        if (noise_err) bus_error = ($urandom_range(0, 1) == 1);
        if (op == 1) begin
          data_valid = go;
          address_data_in = $urandom;
          if (go) rd_exp.push_back(address_data_in);
        end else begin
          bus_busy = !go;
          if (go) wr_got.push_back(address_data_out);
        end
        if (go) begin
          left--;
          if (left == 0) begin in_data = 0; expect_end = 1; end
        end
      end
      @(negedge system_clk);
    end
    launch_read = 0; bus_grant = 0; bus_busy = 0; data_valid = 0; bus_error = 0;
    chk("op_completes", 32'(done_seen), 32'd1);
    chk("busy_during_op", 32'(busy_seen), 32'd1);
    @(negedge system_clk);
    @(negedge system_clk);
    chk("busy_after_op", 32'(busy), 32'd0);
    chk("bus_request_idle", 32'(bus_request), 32'd0);
    rem = (op == 2) ? 0 : int'(block);
    a = addr;
    k = 0;
    while (rem > 0) begin
      b = (int'(burst) + 1 < rem) ? int'(burst) + 1 : rem;
      if (k < got_addr.size()) begin
        chk("burst_addr", got_addr[k], a);
        chk("burst_len", 32'(got_len[k]), 32'(b - 1));
      end
      a = a + 32'(4 * b);
      rem = rem - b;
      k++;
    end
    chk("burst_count", 32'(got_addr.size()), 32'(k));
    chk("end_count", 32'(end_cnt), 32'(k));
    chk("switch_count", 32'(sw_cnt), 32'd1);
    chk("byte_enables", 32'(be_bad), 32'd0);
    chk("read_n_write", 32'(rnw_bad), 32'd0);
    chk("end_after_last_beat", 32'(end_miss), 32'd0);
    if (op == 0) begin
      chk("write_words", 32'(wr_got.size()), 32'(block));
      foreach (wr_got[i]) chk("write_data", wr_got[i], wr_word(i));
    end
    if (op == 1) begin
      exp_bso = block;
      chk("read_words", 32'(rd_exp.size()), 32'(block));
      foreach (rd_exp[i]) chk("read_buffer", pp_mem[i], rd_exp[i]);
    end
    chk("block_size_out", 32'(block_size_out), 32'(exp_bso));
    chk("operation_done", 32'(operation_done), 32'd1);
    chk("error_flag", 32'(error_flag), 32'd0);
  endtask

  typedef struct {
    int          op;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [7:0]  burst;
    logic [7:0]  block;
    bit          alt;
    int          exp_nb;
    logic [31:0] exp_last_addr;
    logic [7:0]  exp_last_len;
  } vec_t;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    int   sws, ends, reqs;
    bit   got;
    vecs[0] = '{0, 32'h0000_1000, 4'hF, 8'd3,  8'd5,  1'b1, 2, 32'h0000_1010, 8'd0};
    vecs[1] = '{1, 32'h0000_2000, 4'h3, 8'd7,  8'd3,  1'b1, 1, 32'h0000_2000, 8'd2};
    vecs[2] = '{0, 32'hFFFF_FFFC, 4'hF, 8'd0,  8'd2,  1'b0, 2, 32'h0000_0000, 8'd0};
    vecs[3] = '{0, 32'h0000_0040, 4'h5, 8'd2,  8'd0,  1'b0, 0, 32'h0,         8'd0};
    vecs[4] = '{1, 32'h0000_0080, 4'hA, 8'd1,  8'd0,  1'b0, 0, 32'h0,         8'd0};
    vecs[5] = '{2, 32'h0000_0000, 4'hF, 8'd0,  8'd0,  1'b0, 0, 32'h0,         8'd0};
    vecs[6] = '{1, 32'h0000_0100, 4'hC, 8'd0,  8'd4,  1'b0, 4, 32'h0000_010C, 8'd0};
    vecs[7] = '{0, 32'h0000_0200, 4'hF, 8'd15, 8'd16, 1'b0, 1, 32'h0000_0200, 8'd15};

    n_reset = 0;
    launch_write = 0; launch_read = 0; launch_simple_switch = 0;
    start_address = 0; byte_enable = 0; burst_size = 0; block_size_in = 0;
    bus_grant = 0; data_valid = 0; bus_busy = 0; bus_error = 0; address_data_in = 0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_operation_done", 32'(operation_done), 32'd0);
    chk("rst_block_size_out", 32'(block_size_out), 32'd0);
    chk("rst_bus_request", 32'(bus_request), 32'd0);
    chk("rst_begin", 32'(begin_transaction), 32'd0);
    chk("rst_end", 32'(end_transaction), 32'd0);
    chk("rst_addr_data", address_data_out, 32'd0);
    chk("rst_byte_enables", 32'(byte_enables_out), 32'hF);
    chk("rst_burst_size_out", 32'(burst_size_out), 32'd0);
    chk("rst_read_n_write", 32'(read_n_write), 32'd0);
    chk("rst_pp_address", 32'(pp_address), 32'd0);
    chk("rst_pp_we", 32'(pp_writeEnable), 32'd0);
    chk("rst_pp_datain", pp_dataIn, 32'd0);
    chk("rst_pp_switch", 32'(pp_switch), 32'd0);
    chk("rst_error_flag", 32'(error_flag), 32'd0);
    @(negedge system_clk);
    n_reset = 1;
    @(negedge system_clk);

    // Directed operations from the table
    for (int v = 0; v < 8; v++) begin
      run_op(vecs[v].op, vecs[v].addr, vecs[v].be, vecs[v].burst, vecs[v].block, vecs[v].alt, 1'b0);
      chk("vec_burst_count", 32'(got_addr.size()), 32'(vecs[v].exp_nb));
      if (vecs[v].exp_nb > 0 && got_addr.size() == vecs[v].exp_nb) begin
        chk("vec_last_addr", got_addr[vecs[v].exp_nb - 1], vecs[v].exp_last_addr);
        chk("vec_last_len", 32'(got_len[vecs[v].exp_nb - 1]), 32'(vecs[v].exp_last_len));
      end
    end

    // Simultaneous write+read launch, then a read launch while busy: only the write runs
    run_op(0, 32'h0000_0600, 4'hF, 8'd1, 8'd2, 1'b0, 1'b1);

    // Randomised operations
`ifndef DMA_SEQ_ERROR_EN
    noise_err = 1'b1;
`endif
    for (int r = 0; r < 12; r++) begin
      run_op(int'($urandom_range(0, 2)), $urandom & 32'hFFFF_FFFC, 4'($urandom),
             8'($urandom_range(0, 7)), 8'($urandom_range(0, 24)), 1'b0, 1'b0);
    end
    noise_err = 1'b0;

    // Reset asserted during the data phase of a 4-beat write burst
    start_address = 32'h500; byte_enable = 4'hF; burst_size = 8'd3; block_size_in = 8'd4;
    launch_write = 1;
    @(negedge system_clk);
    launch_write = 0;
    got = 0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      bus_grant = bus_request;
      if (begin_transaction) begin got = 1; break; end
      @(negedge system_clk);
    end
    chk("rst_mid_reached_init", 32'(got), 32'd1);
    bus_grant = 0; bus_busy = 1;
    @(negedge system_clk);
    chk("rst_mid_in_data", 32'(bus_request), 32'd1);
    #2 n_reset = 0;
    #1;
    chk("rst_mid_bus_request", 32'(bus_request), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_addr_data", address_data_out, 32'd0);
    chk("rst_mid_end", 32'(end_transaction), 32'd0);
    chk("rst_mid_pp_switch", 32'(pp_switch), 32'd0);
    chk("rst_mid_pp_address", 32'(pp_address), 32'd0);
    chk("rst_mid_byte_enables", 32'(byte_enables_out), 32'hF);
    @(negedge system_clk);
    n_reset = 1; bus_busy = 0;
    sws = 0; ends = 0; reqs = 0;
    repeat (10) begin
      @(negedge system_clk);
      if (pp_switch) sws++;
      if (end_transaction) ends++;
      if (bus_request) reqs++;
    end
    exp_bso = 8'd0;
    chk("rst_mid_no_switch", 32'(sws), 32'd0);
    chk("rst_mid_no_end", 32'(ends), 32'd0);
    chk("rst_mid_idle", 32'(reqs), 32'd0);
    chk("rst_mid_done", 32'(operation_done), 32'd0);
    chk("rst_mid_bso", 32'(block_size_out), 32'(exp_bso));

`ifdef DMA_SEQ_ERROR_EN
    // Bus error on the second beat of an 8-word read: abort, no further burst, no buffer switch
    begin : err_case
      int  k, begins, e_ends, e_sws;
      bit  seen_done, end_ok;
      k = -1; begins = 0; e_ends = 0; e_sws = 0; seen_done = 0; end_ok = 0;
      start_address = 32'h3000; byte_enable = 4'hF; burst_size = 8'd7; block_size_in = 8'd8;
      launch_read = 1;
      @(negedge system_clk);
      launch_read = 0;
      for (int cyc = 0; cyc < 500; cyc++) begin
        if (operation_done) begin seen_done = 1; break; end
        data_valid = 0; bus_error = 0;
        bus_grant = bus_request;
        if (end_transaction) e_ends++;
        if (pp_switch) e_sws++;
        if (begin_transaction) begin
          begins++; k = 0;
        end else if (k == 0) begin
          data_valid = 1; address_data_in = $urandom; k = 1;
        end else if (k == 1) begin
          bus_error = 1; k = 2;
        end else if (k == 2) begin
          end_ok = end_transaction; k = 3;
        end
        @(negedge system_clk);
      end
      data_valid = 0; bus_error = 0; bus_grant = 0;
      chk("err_completes", 32'(seen_done), 32'd1);
      chk("err_end_follows", 32'(end_ok), 32'd1);
      chk("err_single_burst", 32'(begins), 32'd1);
      chk("err_end_count", 32'(e_ends), 32'd1);
      chk("err_no_switch", 32'(e_sws), 32'd0);
      chk("err_flag", 32'(error_flag), 32'd1);
      chk("err_done", 32'(operation_done), 32'd1);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
